// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bin, DIGIT bits per clock, LSB slice first,
// with the inter-slice borrow kept as an inverted carry. Valid/ready on both sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({DIGIT{1'b1}});

  if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [31:0]      base;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] nb_sl;
  logic [DIGIT-1:0] s_sl;
  logic             c_d;
  logic             cin_msb;
  logic             last;
  logic [WIDTH-1:0] d_d;

  // Current slice: a + ~b + c; the carry into the top bit feeds signed overflow.
  always_comb begin
    base    = 32'(cnt_q) * DIGIT;
    a_sl    = DIGIT'(a_q >> base);
    nb_sl   = ~DIGIT'(b_q >> base);
    {c_d, s_sl} = {1'b0, a_sl} + {1'b0, nb_sl} + (DIGIT+1)'(c_q);
    cin_msb = a_sl[DIGIT-1] ^ nb_sl[DIGIT-1] ^ s_sl[DIGIT-1];
    last    = (cnt_q == CW'(N - 1));
    d_d     = (d_q & ~(SLICE_MASK << base)) | (WIDTH'(s_sl) << base);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= ~bin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          d_q <= d_d;
          c_q <= c_d;
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            borrow_q    <= ~c_d;
            ovf_q       <= cin_msb ^ c_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign d          = d_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases on WIDTH=8/DIGIT=2, random
// back-to-back traffic with random out_ready on 8/8 and 16/4 instances.
module tb_serial_subtractor;

  localparam int NOPS       = 1000;
  localparam int CYC_BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        ovf;
    logic        bo;
    logic [15:0] d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic       rst0, iv0, ir0, bin0, ov0, or0, bo0, of0;
  logic [7:0] a0, b0, d0;
  logic       rst12;
  logic       iv1, ir1, bin1, ov1, or1, bo1, of1;
  logic [7:0] a1, b1, d1;
  logic       iv2, ir2, bin2, ov2, or2, bo2, of2;
  logic [15:0] a2, b2, d2;

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .bin(bin0),
    .out_valid(ov0), .out_ready(or0), .d(d0), .borrow_out(bo0), .overflow(of0));

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_dut1 (
    .clk(clk), .rst(rst12), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .bin(bin1),
    .out_valid(ov1), .out_ready(or1), .d(d1), .borrow_out(bo1), .overflow(of1));

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut2 (
    .clk(clk), .rst(rst12), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .bin(bin2),
    .out_valid(ov2), .out_ready(or2), .d(d2), .borrow_out(bo2), .overflow(of2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference via plain wide integer arithmetic on w-bit operands.
  function automatic exp_t ref_sub(input int unsigned w, input logic [15:0] a,
                                   input logic [15:0] b, input logic bin);
    exp_t        e;
    logic [31:0] full;
    logic [15:0] mask;
    logic [3:0]  msb;
    mask  = 16'((32'd1 << w) - 32'd1);
    msb   = 4'(w - 1);
    full  = {16'd0, a} - {16'd0, b} - 32'(bin);
    e.d   = full[15:0] & mask;
    e.bo  = ({16'd0, a} < ({16'd0, b} + 32'(bin)));
    e.ovf = (a[msb] != b[msb]) && (e.d[msb] != a[msb]);
    return e;
  endfunction

  task automatic run_op0(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input int hold, input logic early);
    exp_t       e;
    int         cyc;
    logic [7:0] d_h;
    logic [1:0] fl_h;
    check("ready_idle", ir0, 1);
    a0 = a; b0 = b; bin0 = bin; iv0 = 1'b1; or0 = early;
    q0.push_back(ref_sub(8, 16'(a), 16'(b), bin));
    @(negedge clk);
    iv0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom); bin0 = 1'($urandom);
    check("ready_run", ir0, 0);
    cyc = 0;
    while (!ov0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 4);
    e = q0.pop_front();
    check("d", d0, e.d[7:0]);
    check("borrow", bo0, e.bo);
    check("ovf", of0, e.ovf);
    d_h  = d0;
    fl_h = {bo0, of0};
    for (int i = 0; i < hold; i++) begin
      iv0 = 1'($urandom);
      @(negedge clk);
      check("hold_valid", ov0, 1);
      check("hold_d", d0, d_h);
      check("hold_flags", {bo0, of0}, fl_h);
      check("hold_ready", ir0, 0);
    end
    iv0 = 1'b0; or0 = 1'b1;
    @(negedge clk);
    check("consumed", ov0, 0);
    check("ready_after", ir0, 1);
    or0 = 1'b0;
  endtask

  task automatic reset_mid_run0();
    check("ready_pre_abort", ir0, 1);
    a0 = 8'h55; b0 = 8'h11; bin0 = 1'b0; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1; iv0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0; iv0 = 1'b0;
    check("abort_ready", ir0, 1);
    check("abort_valid", ov0, 0);
    check("abort_d", d0, 0);
    check("abort_flags", {bo0, of0}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_pulse", ov0, 0);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst12 = 1'b1;
    iv0 = 0; or0 = 0; a0 = 0; b0 = 0; bin0 = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0; bin1 = 0;
    iv2 = 0; or2 = 0; a2 = 0; b2 = 0; bin2 = 0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst12 = 1'b0;
    check("rst_ready", ir0, 1);
    check("rst_valid", ov0, 0);
    check("rst_d", d0, 0);
    check("rst_flags", {bo0, of0}, 0);
    check("rst_d16", d2, 0);

    fork
      begin : directed
        run_op0(8'h05, 8'h03, 1'b0, 0, 1'b0);
        run_op0(8'h80, 8'h01, 1'b0, 0, 1'b1);
        run_op0(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
        run_op0(8'h00, 8'h01, 1'b0, 0, 1'b1);
        run_op0(8'h10, 8'h0F, 1'b1, 10, 1'b0);
        reset_mid_run0();
        run_op0(8'h20, 8'h01, 1'b0, 0, 1'b0);
        check("q0_empty", q0.size(), 0);
      end

      begin : rnd1
        int   acc, done, cyc, acc_cyc;
        logic seen;
        exp_t e;
        acc = 0; done = 0; cyc = 0; acc_cyc = 0; seen = 1'b0;
        while (done < NOPS && cyc < CYC_BUDGET) begin
          @(negedge clk);
          cyc++;
          or1 = 1'($urandom);
          if (ov1) begin
            check("r1_ready_busy", ir1, 0);
            if (q1.size() == 0) check("r1_spurious", ov1, 0);
            else begin
              e = q1[0];
              if (!seen) begin
                check("r1_latency", cyc - acc_cyc - 1, 1);
                seen = 1'b1;
              end
              check("r1_d", d1, e.d[7:0]);
              check("r1_flags", {bo1, of1}, {e.bo, e.ovf});
              if (or1) begin
                void'(q1.pop_front());
                seen = 1'b0;
                done++;
              end
            end
          end
          if (ir1 && acc < NOPS) begin
            iv1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom); bin1 = 1'($urandom);
            q1.push_back(ref_sub(8, 16'(a1), 16'(b1), bin1));
            acc_cyc = cyc;
            acc++;
          end else begin
            iv1 = ir1 ? 1'b0 : 1'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); bin1 = 1'($urandom);
          end
        end
        check("r1_completed", done, NOPS);
        iv1 = 1'b0; or1 = 1'b0;
      end

      begin : rnd2
        int   acc, done, cyc, acc_cyc;
        logic seen;
        exp_t e;
        acc = 0; done = 0; cyc = 0; acc_cyc = 0; seen = 1'b0;
        while (done < NOPS && cyc < CYC_BUDGET) begin
          @(negedge clk);
          cyc++;
          or2 = 1'($urandom);
          if (ov2) begin
            check("r2_ready_busy", ir2, 0);
            if (q2.size() == 0) check("r2_spurious", ov2, 0);
            else begin
              e = q2[0];
              if (!seen) begin
                check("r2_latency", cyc - acc_cyc - 1, 4);
                seen = 1'b1;
              end
              check("r2_d", d2, e.d);
              check("r2_flags", {bo2, of2}, {e.bo, e.ovf});
              if (or2) begin
                void'(q2.pop_front());
                seen = 1'b0;
                done++;
              end
            end
          end
          if (ir2 && acc < NOPS) begin
            iv2 = 1'b1; a2 = 16'($urandom); b2 = 16'($urandom); bin2 = 1'($urandom);
            q2.push_back(ref_sub(16, a2, b2, bin2));
            acc_cyc = cyc;
            acc++;
          end else begin
            iv2 = ir2 ? 1'b0 : 1'($urandom);
            a2 = 16'($urandom); b2 = 16'($urandom); bin2 = 1'($urandom);
          end
        end
        check("r2_completed", done, NOPS);
        iv2 = 1'b0; or2 = 1'b0;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
